// File: rtl/des_key_sweep.sv
// Key-search controller: sweeps a count range, issues odd-parity DES keys one per
// cycle to a fixed-latency engine and latches the first key whose result matches.
module des_key_sweep #(
    parameter int          LAT         = 16,
    parameter logic [55:0] START_COUNT = 56'h0,
    parameter logic [55:0] LAST_COUNT  = 56'hFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [63:0] ciphertext,
    input  logic [63:0] enc_result,
    output logic [63:0] des_key,
    output logic        des_key_valid,
    output logic [55:0] count,
    output logic [63:0] Key,
    output logic        Found,
    output logic        Done,
    output logic        busy
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEARCH = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_FOUND  = 3'd3;
    localparam logic [2:0] S_EXH    = 3'd4;

    logic [2:0]     state;
    logic [LAT-1:0] vld_pipe;
    logic [LAT-1:0] vld_next;
    logic [55:0]    cnt_pipe [LAT];
    logic           active;
    logic           issue;
    logic           match;

    // 7 count bits per key byte, LSB of each byte makes the byte odd parity
    function automatic logic [63:0] expand(input logic [55:0] c);
        logic [63:0] k;
        k = '0;
        for (int i = 0; i < 8; i++) begin
            k[63-8*i -: 7] = c[55-7*i -: 7];
            k[56-8*i]      = ~^c[55-7*i -: 7];
        end
        return k;
    endfunction

    assign active   = (state == S_SEARCH) || (state == S_DRAIN);
    assign issue    = (state == S_SEARCH);
    assign vld_next = LAT'({vld_pipe, issue});
    assign match    = vld_pipe[LAT-1] && (enc_result == ciphertext);

    // Tag valids: the tap entry pairs with the current enc_result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
        end else if (match || !active) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= vld_next;
        end
    end

    always_ff @(posedge clk) begin
        cnt_pipe[0] <= count;
        for (int i = 1; i < LAT; i++) cnt_pipe[i] <= cnt_pipe[i-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            des_key       <= '0;
            des_key_valid <= 1'b0;
            count         <= '0;
            Key           <= '0;
            Found         <= 1'b0;
            Done          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_FOUND, S_EXH: begin
                    if (Start) begin
                        state         <= S_SEARCH;
                        count         <= START_COUNT;
                        des_key       <= expand(START_COUNT);
                        des_key_valid <= 1'b1;
                        Key           <= '0;
                        Found         <= 1'b0;
                        Done          <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                S_SEARCH, S_DRAIN: begin
                    if (match) begin
                        state         <= S_FOUND;
                        count         <= cnt_pipe[LAT-1];
                        Key           <= expand(cnt_pipe[LAT-1]);
                        des_key       <= '0;
                        des_key_valid <= 1'b0;
                        Found         <= 1'b1;
                        Done          <= 1'b1;
                        busy          <= 1'b0;
                    end else if (state == S_SEARCH) begin
                        // stop at the last count rather than wrapping the counter
                        if (count == LAST_COUNT) begin
                            state         <= S_DRAIN;
                            des_key       <= '0;
                            des_key_valid <= 1'b0;
                        end else begin
                            count   <= count + 56'd1;
                            des_key <= expand(count + 56'd1);
                        end
                    end else if (vld_next == '0) begin
                        state <= S_EXH;
                        count <= LAST_COUNT;
                        Done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_key_sweep.sv
// Bench for des_key_sweep: three sweep configurations driven against a 4-cycle
// XOR engine model, with a key scoreboard on the main instance.
module tb_des_key_sweep;
    localparam int          LAT  = 4;
    localparam logic [63:0] PAT  = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [55:0] MAXC = 56'hFF_FFFF_FFFF_FFFF;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic [2:0]                start = '0;
    logic [2:0][63:0]          ct    = '0;
    logic [2:0][63:0]          res;
    logic [2:0][63:0]          dk;
    logic [2:0]                kv;
    logic [2:0][55:0]          cnt;
    logic [2:0][63:0]          key;
    logic [2:0]                fnd;
    logic [2:0]                dn;
    logic [2:0]                bsy;
    logic [2:0][LAT-1:0][63:0] eng = '0;

    int n_chk  = 0;
    int n_pass = 0;
    int nkeys  = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    des_key_sweep #(.LAT(LAT), .START_COUNT(56'd0), .LAST_COUNT(56'd15)) u0 (
        .clk(clk), .reset(reset), .Start(start[0]), .ciphertext(ct[0]), .enc_result(res[0]),
        .des_key(dk[0]), .des_key_valid(kv[0]), .count(cnt[0]), .Key(key[0]),
        .Found(fnd[0]), .Done(dn[0]), .busy(bsy[0]));
    des_key_sweep #(.LAT(LAT), .START_COUNT(MAXC), .LAST_COUNT(MAXC)) u1 (
        .clk(clk), .reset(reset), .Start(start[1]), .ciphertext(ct[1]), .enc_result(res[1]),
        .des_key(dk[1]), .des_key_valid(kv[1]), .count(cnt[1]), .Key(key[1]),
        .Found(fnd[1]), .Done(dn[1]), .busy(bsy[1]));
    des_key_sweep #(.LAT(LAT), .START_COUNT(56'd0), .LAST_COUNT(56'd7)) u2 (
        .clk(clk), .reset(reset), .Start(start[2]), .ciphertext(ct[2]), .enc_result(res[2]),
        .des_key(dk[2]), .des_key_valid(kv[2]), .count(cnt[2]), .Key(key[2]),
        .Found(fnd[2]), .Done(dn[2]), .busy(bsy[2]));

    // engine model: captures des_key each edge, returns key ^ PAT LAT edges later
    always @(posedge clk) begin
        for (int u = 0; u < 3; u++) eng[u] <= {eng[u][LAT-2:0], dk[u]};
    end
    always_comb begin
        res = '0;
        for (int u = 0; u < 3; u++) res[u] = eng[u][LAT-1] ^ PAT;
    end

    function automatic logic [63:0] exp_key(input logic [55:0] c);
        logic [63:0] k;
        logic [6:0]  b;
        k = '0;
        for (int i = 0; i < 8; i++) begin
            b = c[7*(7-i) +: 7];
            k = {k[55:0], b, ($countones(b) % 2 == 0)};
        end
        return k;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic chk_zero(input string pfx, input int u);
        chk({pfx, "_des_key"}, dk[u], 64'd0);
        chk({pfx, "_key_valid"}, 64'(kv[u]), 64'd0);
        chk({pfx, "_count"}, 64'(cnt[u]), 64'd0);
        chk({pfx, "_Key"}, key[u], 64'd0);
        chk({pfx, "_Found"}, 64'(fnd[u]), 64'd0);
        chk({pfx, "_Done"}, 64'(dn[u]), 64'd0);
        chk({pfx, "_busy"}, 64'(bsy[u]), 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start is sampled at the next edge (E0); returns 1 time unit after E0
    task automatic start_u(input int u);
        start[u] = 1'b1;
        step();
        start[u] = 1'b0;
    endtask

    task automatic push_keys(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) exp_q.push_back(exp_key(56'(c)));
    endtask

    // scoreboard on the main instance: every live key must be the next expected one
    always @(negedge clk) begin
        if (reset && kv[0]) begin
            nkeys++;
            chk("key_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("des_key_seq", dk[0], exp_q.pop_front());
        end
    end

    initial begin
        // reset held with Start asserted
        start = '1;
        repeat (3) step();
        chk_zero("rst", 0);
        chk_zero("rst_u2", 2);
        start = '0;
        step();
        reset = 1'b1;
        step();

        // exhaust sweep 0..15, with a stray Start mid-search
        ct[0] = 64'd0;
        push_keys(0, 15);
        nkeys = 0;
        start_u(0);
        chk("exh_busy_e0", 64'(bsy[0]), 64'd1);
        chk("exp_key0", dk[0], 64'h0101010101010101);
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 1) chk("exp_key1", dk[0], 64'h0101010101010102);
            if (e == 5) begin
                chk("exp_key5", dk[0], 64'h010101010101010B);
                chk("exh_count5", 64'(cnt[0]), 64'd5);
            end
            if (e == 7) start[0] = 1'b1;
            if (e == 8) start[0] = 1'b0;
            if (e == 19) begin
                chk("exh_done_e19", 64'(dn[0]), 64'd0);
                chk("exh_busy_e19", 64'(bsy[0]), 64'd1);
            end
        end
        chk("exh_done", 64'(dn[0]), 64'd1);
        chk("exh_busy", 64'(bsy[0]), 64'd0);
        chk("exh_found", 64'(fnd[0]), 64'd0);
        chk("exh_count", 64'(cnt[0]), 64'd15);
        chk("exh_Key", key[0], 64'd0);
        repeat (2) step();
        chk("exh_nkeys", 64'(nkeys), 64'd16);
        chk("exh_q_empty", 64'(exp_q.size()), 64'd0);

        // match at count 5, started from EXHAUSTED
        ct[0] = exp_key(56'd5) ^ PAT;
        push_keys(0, 9);
        nkeys = 0;
        start_u(0);
        chk("m_done_clr", 64'(dn[0]), 64'd0);
        chk("m_busy_e0", 64'(bsy[0]), 64'd1);
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e == 9) chk("m_found_e9", 64'(fnd[0]), 64'd0);
        end
        chk("m_found", 64'(fnd[0]), 64'd1);
        chk("m_done", 64'(dn[0]), 64'd1);
        chk("m_count", 64'(cnt[0]), 64'd5);
        chk("m_Key", key[0], 64'h010101010101010B);
        chk("m_valid_low", 64'(kv[0]), 64'd0);
        repeat (3) step();
        chk("m_valid_low_late", 64'(kv[0]), 64'd0);
        chk("m_nkeys", 64'(nkeys), 64'd10);
        chk("m_q_empty", 64'(exp_q.size()), 64'd0);

        // Start in FOUND restarts the sweep
        push_keys(0, 9);
        start_u(0);
        chk("rs_found_clr", 64'(fnd[0]), 64'd0);
        chk("rs_done_clr", 64'(dn[0]), 64'd0);
        chk("rs_first_key", dk[0], exp_key(56'd0));
        repeat (10) step();
        chk("rs_found", 64'(fnd[0]), 64'd1);
        chk("rs_count", 64'(cnt[0]), 64'd5);
        chk("rs_q_empty", 64'(exp_q.size()), 64'd0);

        // reset dropped mid-search, Start ignored while held
        push_keys(0, 3);
        start_u(0);
        repeat (3) step();
        #5;
        reset = 1'b0;
        #1;
        chk_zero("rmid", 0);
        exp_q.delete();
        start[0] = 1'b1;
        repeat (2) step();
        chk("rmid_hold_valid", 64'(kv[0]), 64'd0);
        chk("rmid_hold_busy", 64'(bsy[0]), 64'd0);
        start[0] = 1'b0;
        reset = 1'b1;
        step();
        push_keys(0, 9);
        start_u(0);
        chk("rmid_first_key", dk[0], exp_key(56'd0));
        chk("rmid_first_count", 64'(cnt[0]), 64'd0);
        repeat (10) step();
        chk("rmid_found", 64'(fnd[0]), 64'd1);
        chk("rmid_q_empty", 64'(exp_q.size()), 64'd0);

        // single-count sweep at the top of the counter range
        ct[1] = 64'd0;
        start_u(1);
        chk("max_key", dk[1], 64'hFEFEFEFEFEFEFEFE);
        chk("max_valid", 64'(kv[1]), 64'd1);
        chk("max_count", 64'(cnt[1]), 64'(MAXC));
        step();
        chk("max_drain_valid", 64'(kv[1]), 64'd0);
        chk("max_drain_busy", 64'(bsy[1]), 64'd1);
        for (int e = 2; e <= 5; e++) begin
            step();
            if (e == 4) chk("max_done_e4", 64'(dn[1]), 64'd0);
        end
        chk("max_done", 64'(dn[1]), 64'd1);
        chk("max_found", 64'(fnd[1]), 64'd0);
        chk("max_end_count", 64'(cnt[1]), 64'(MAXC));
        chk("max_busy", 64'(bsy[1]), 64'd0);

        // match on the last count of the range
        ct[2] = exp_key(56'd7) ^ PAT;
        start_u(2);
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 11) chk("last_found_e11", 64'(fnd[2]), 64'd0);
        end
        chk("last_found", 64'(fnd[2]), 64'd1);
        chk("last_done", 64'(dn[2]), 64'd1);
        chk("last_count", 64'(cnt[2]), 64'd7);
        chk("last_Key", key[2], 64'h010101010101010E);
        repeat (4) step();
        chk("last_found_held", 64'(fnd[2]), 64'd1);
        chk("last_count_held", 64'(cnt[2]), 64'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/des_key_sweep.md
# des_key_sweep

Key-search controller for the DES cracker, directly upstream of the pipelined DES encryption engine. On `Start` it sweeps a 56-bit key counter across a programmable range and expands each count into a 64-bit odd-parity DES key, issuing one key per cycle. It tracks in-flight keys through the engine's fixed latency and compares each returned encryption against the target ciphertext. It reports the first matching `Key`/`count` with `Found`, or signals exhaustion.

## Interface
- `LAT`, 16: fixed DES engine latency in cycles, ≥1.
- `START_COUNT`, 56'h0: first count issued.
- `LAST_COUNT`, 56'hFF_FFFF_FFFF_FFFF: last count issued, inclusive, ≥ `START_COUNT`.

- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `Start` in 1: start pulse; sampled on rising edge.
- `ciphertext` in 64: target ciphertext; held stable during a search.
- `enc_result` in 64: engine output for the key captured `LAT` edges earlier.
- `des_key` out 64: expanded key to the engine.
- `des_key_valid` out 1: `des_key` is a live key this cycle.
- `count` out 56: see Operation.
- `Key` out 64: matched key.
- `Found` out 1: match found.
- `Done` out 1: search finished, found or exhausted.
- `busy` out 1: state is SEARCH or DRAIN.

## Operation
- Key expansion of count c:
  - Key byte i (i=0 is `[63:56]`) takes `c[55-7i -: 7]` in bits `[7:1]`.
  - Bit 0 is the odd-parity bit, equal to the XNOR-reduce of the 7 bits.
- Tag pipeline: `LAT`-deep shift register of {valid, count}, advancing every cycle. The tap entry pairs with the current `enc_result`.
- Match: tap valid && `enc_result == ciphertext`.
- FSM states:
  - IDLE: all outputs 0. `Start` → SEARCH; issue counter ← `START_COUNT`; tag valids cleared.
  - SEARCH:
    - `des_key_valid`=1, `des_key`=expand(issue counter); tag shifts in {1, counter}; counter++.
    - The cycle issuing `LAST_COUNT` → DRAIN.
    - `count` shows the issue counter.
  - DRAIN: no issue, `des_key_valid`=0; tag shifts in {0, x}. Tag empty with no match → EXHAUSTED.
  - FOUND:
    - `Found`=1, `Done`=1.
    - `count` = matched tag count; `Key` = expand(matched count). Both held.
    - Tag valids cleared.
  - EXHAUSTED: `Done`=1, `Found`=0, `count`=`LAST_COUNT`, `Key`=0.
- Match in SEARCH or DRAIN → FOUND, with priority over all other transitions.
- Results arrive in issue order, so the first match is the lowest matching count. Later in-flight results are discarded.
- `Start` is ignored in SEARCH and DRAIN. In FOUND or EXHAUSTED it restarts as from IDLE, and `Found`/`Done` clear on that edge.
- Counter arithmetic is 56-bit unsigned. `LAST_COUNT` = 2^56-1 terminates via the DRAIN transition without wrapping.

## Timing
- Reset (asynchronous, `reset`=0):
  - State IDLE; tag valids cleared.
  - `des_key`, `des_key_valid`, `count`, `Key`, `Found`, `Done`, `busy` all 0 immediately.
- All outputs are registered.
- `Start` sampled at edge E0. Key offset k (count `START_COUNT`+k):
  - Driven in the cycle after E(k).
  - Captured by the engine at E(1+k).
  - Result sampled at E(1+k+LAT).
  - On a match, `Found` is high after E(1+k+LAT).
- `busy` is high after E0.
- No match: `Done` is high after E(N+LAT), where N = `LAST_COUNT`-`START_COUNT`+1.
- Throughput: one key per cycle, no bubbles.
- Reset mid-search aborts immediately with no residual outputs. The next `Start` begins at `START_COUNT`.

## Test plan
Bench engine model: `LAT`=4, result = key XOR 64'hA5A5_A5A5_A5A5_A5A5, delayed 4 cycles.

- Reset: hold `reset`=0 with `clk` running → every output 0; `Start` has no effect.
- Expansion: observe `des_key` at counts 0, 1, 5, and at 2^56-1 (set `START_COUNT`=`LAST_COUNT`=2^56-1).
  - Expected keys: 0101010101010101, 0101010101010102, 010101010101010B, FEFEFEFEFEFEFEFE.
- Match: `START_COUNT`=0, `ciphertext` = expand(5) XOR A5…A5, `Start` at E0.
  - `Found`=1 and `Done`=1 after E10; `count`=5; `Key`=010101010101010B.
  - `des_key_valid` low from then on.
- Exhaust: `LAST_COUNT`=15, no matching ciphertext.
  - `busy` high after E0 until `Done` rises after E20.
  - `Found`=0; `count`=15; exactly 16 `des_key_valid` cycles.
- Last-key match: `LAST_COUNT`=7, target = expand(7) XOR pattern → `Found`=1 after E12, `count`=7, never EXHAUSTED.
- Control corners:
  - `Start` pulsed mid-SEARCH → ignored; the sweep is unaltered.
  - `reset` dropped mid-SEARCH → outputs 0 at once.
  - After release, `Start` → first `des_key` = expand(`START_COUNT`).
  - `Start` in FOUND → `Found` clears; a new sweep begins.
